// File: rtl/sq_iter_squarer_pkg.sv
// sq_iter_squarer_pkg: FSM state encodings and operand-width legality helper for the iterative squarer
package sq_iter_squarer_pkg;

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_CALC = 2'd1,
        SQ_DONE = 2'd2
    } sq_state_t;

    localparam int SQ_MIN_W = 2;
    localparam int SQ_MAX_W = 16;

    function automatic bit sq_width_ok(input int w);
        return (w >= SQ_MIN_W) && (w <= SQ_MAX_W);
    endfunction

endpackage

// File: rtl/sq_shift_add_dp.sv
// sq_shift_add_dp: one combinational shift-add step (conditional add, then shift multiplicand left and multiplier right)
module sq_shift_add_dp #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    // add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_nxt    = mplier[0] ? acc + mcand : acc;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
    end

endmodule

// File: rtl/sq_iter_squarer.sv
// sq_iter_squarer: sequential sign-magnitude squarer with valid/ready handshakes; SQ_EARLY_DONE_EN finishes once the multiplier empties
module sq_iter_squarer
    import sq_iter_squarer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   n,
    input  logic               sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] square,
    output logic               out_sign,
    output logic               busy
);

    localparam int OUT_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    if (!sq_width_ok(WIDTH)) begin : g_bad_width
        $error("sq_iter_squarer: WIDTH must be within 2..16");
    end

    sq_state_t        state;
    logic [OUT_W-1:0] acc, mcand, acc_nxt, mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;

    sq_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    // final iteration: fixed count, or as soon as no multiplier bits remain
    always_comb begin
`ifdef SQ_EARLY_DONE_EN
        last = (mplier_nxt == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
        last = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    assign in_ready  = (state == SQ_IDLE);
    assign out_valid = (state == SQ_DONE);
    assign busy      = (state != SQ_IDLE);

    // handshake FSM and iteration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SQ_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            square   <= '0;
            out_sign <= 1'b0;
        end else begin
            case (state)
                SQ_IDLE: if (in_valid) begin
                    mcand    <= {{WIDTH{1'b0}}, n};
                    mplier   <= n;
                    acc      <= '0;
                    cnt      <= '0;
                    out_sign <= sign;
                    state    <= SQ_CALC;
                end
                SQ_CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        square <= acc_nxt;
                        state  <= SQ_DONE;
                    end
                end
                SQ_DONE: if (out_ready) state <= SQ_IDLE;
                default: state <= SQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sq_iter_squarer.sv
// tb_sq_iter_squarer: directed bench for sq_iter_squarer at WIDTH=4 and WIDTH=8; honours SQ_EARLY_DONE_EN
module tb_sq_iter_squarer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv4 = 1'b0, or4 = 1'b0, sg4 = 1'b0;
    logic [3:0] n4 = '0;
    logic       ir4, ov4, os4, bz4;
    logic [7:0] sq4;

    logic       iv8 = 1'b0, or8 = 1'b0, sg8 = 1'b0;
    logic [7:0] n8 = '0;
    logic       ir8, ov8, os8, bz8;
    logic [15:0] sq8;

    int total = 0;
    int bad   = 0;

    sq_iter_squarer #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .n(n4), .sign(sg4),
        .out_valid(ov4), .out_ready(or4), .square(sq4), .out_sign(os4), .busy(bz4)
    );

    sq_iter_squarer #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .n(n8), .sign(sg8),
        .out_valid(ov8), .out_ready(or8), .square(sq8), .out_sign(os8), .busy(bz8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // accept one operand on u4, wait for out_valid, check result; optionally pop
    task automatic op4(input logic [3:0] n, input logic s, input int exp_sq,
                       input int lat_full, input int lat_early, input bit pop);
        int lat;
        int exp_lat;
`ifdef SQ_EARLY_DONE_EN
        exp_lat = lat_early;
`else
        exp_lat = lat_full;
`endif
        @(negedge clk);
        chk("w4 in_ready before accept", 32'(ir4), 1);
        n4 = n; sg4 = s; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; n4 = 4'hf; sg4 = ~s;
        chk("w4 busy after accept", 32'(bz4), 1);
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("w4 latency n=%0d", n), 32'(lat), 32'(exp_lat));
        chk($sformatf("w4 square n=%0d", n), 32'(sq4), 32'(exp_sq));
        chk($sformatf("w4 out_sign n=%0d", n), 32'(os4), 32'(s));
        if (pop) begin
            @(negedge clk); or4 = 1'b1;
            @(posedge clk); #1; or4 = 1'b0;
            chk("w4 in_ready after pop", 32'(ir4), 1);
        end
    endtask

    task automatic op8(input logic [7:0] n, input logic s, input int exp_sq, input int exp_lat);
        int lat;
        @(negedge clk);
        n8 = n; sg8 = s; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("w8 latency n=%0d", n), 32'(lat), 32'(exp_lat));
        chk($sformatf("w8 square n=%0d", n), 32'(sq8), 32'(exp_sq));
        chk($sformatf("w8 out_sign n=%0d", n), 32'(os8), 32'(s));
        @(negedge clk); or8 = 1'b1;
        @(posedge clk); #1; or8 = 1'b0;
        chk("w8 in_ready after pop", 32'(ir8), 1);
    endtask

    initial begin
        iv4 = 1'b1; n4 = 4'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(ir4), 1);
        chk("reset out_valid", 32'(ov4), 0);
        chk("reset busy", 32'(bz4), 0);
        chk("reset square", 32'(sq4), 0);
        chk("reset out_sign", 32'(os4), 0);
        iv4 = 1'b0;
        @(negedge clk); rst = 1'b0;

        op4(4'd15, 1'b0, 225, 4, 4, 1'b1);
        op4(4'd5,  1'b0, 25,  4, 3, 1'b1);
        op4(4'd9,  1'b1, 81,  4, 4, 1'b1);
        op4(4'd1,  1'b0, 1,   4, 1, 1'b1);
        op4(4'd8,  1'b1, 64,  4, 4, 1'b1);
        op4(4'd12, 1'b1, 144, 4, 4, 1'b1);
        op4(4'd0,  1'b0, 0,   4, 1, 1'b1);

        // backpressure with a competing operand that must be ignored
        op4(4'd7, 1'b1, 49, 4, 3, 1'b0);
        @(negedge clk); iv4 = 1'b1; n4 = 4'd2; or4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold square", 32'(sq4), 49);
            chk("hold in_ready", 32'(ir4), 0);
            chk("hold out_valid", 32'(ov4), 1);
        end
        iv4 = 1'b0;
        @(negedge clk); or4 = 1'b1;
        @(posedge clk); #1; or4 = 1'b0;
        chk("hold pop in_ready", 32'(ir4), 1);
        chk("hold pop out_valid", 32'(ov4), 0);

        // reset two cycles into CALC
        @(negedge clk); n4 = 4'd13; sg4 = 1'b1; iv4 = 1'b1;
        @(posedge clk); #1; iv4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("midcalc rst out_valid", 32'(ov4), 0);
        chk("midcalc rst busy", 32'(bz4), 0);
        chk("midcalc rst square", 32'(sq4), 0);
        chk("midcalc rst out_sign", 32'(os4), 0);
        chk("midcalc rst in_ready", 32'(ir4), 1);
        @(negedge clk); rst = 1'b0;
        op4(4'd3, 1'b0, 9, 4, 2, 1'b1);

        op8(8'd255, 1'b1, 65025, 8);
        op8(8'd128, 1'b0, 16384, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
